// File: rtl/parking_gate_scheduler.sv
// parking_gate_scheduler
//   Sequences one shared parking gate between an entry lane and an exit lane.
//   A round-robin pointer arbitrates the lanes, arriving cars get the lowest
//   free slot, and leaving cars release the slot they name.  Every grant opens
//   the door for DOOR_CYCLES cycles, followed by one closed HOLD cycle before
//   the next grant can be made.
//
// Handshake: entry_req / exit_req are levels held by the requester until it
//   sees a one-cycle response pulse (entry_ack/entry_deny, exit_ack/exit_err),
//   and are dropped the cycle after that pulse.  A lane is only sampled while
//   the FSM is IDLE, so a request held through OPEN/HOLD simply waits.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   entry_req       car waiting at the entry lane
//   exit_req        car waiting at the exit lane, exit_slot names its slot
//   entry_ack       grant pulse for entry, alloc_slot valid in the same cycle
//   exit_ack        grant pulse for exit
//   entry_deny      entry refused, lot full
//   exit_err        exit refused, exit_slot was not occupied
//   alloc_slot      slot of the most recent entry grant
//   door_open       gate open
//   occupancy       bit i set = slot i occupied
//   free_count      number of free slots (0..4)
//   full            all four slots occupied
//   state_dbg       current FSM state (0 IDLE, 1 OPEN, 2 HOLD)
module parking_gate_scheduler #(
  parameter int DOOR_CYCLES = 8,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_req,
  input  logic       exit_req,
  input  logic [1:0] exit_slot,
  output logic       entry_ack,
  output logic       exit_ack,
  output logic       entry_deny,
  output logic       exit_err,
  output logic [1:0] alloc_slot,
  output logic       door_open,
  output logic [3:0] occupancy,
  output logic [2:0] free_count,
  output logic       full,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } state_t;

  // The timer counts down from DOOR_CYCLES-1 to 0 while OPEN; the door drops on
  // the edge that sees 0, giving exactly DOOR_CYCLES open cycles.
  localparam logic [CNT_W-1:0] TIMER_LOAD = CNT_W'(DOOR_CYCLES - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic             ptr_exit, ptr_exit_nxt;  // 1: exit lane wins a tie
  logic [3:0]       occ_nxt;
  logic [1:0]       alloc_nxt;
  logic             door_nxt;
  logic             entry_ack_nxt, exit_ack_nxt, entry_deny_nxt, exit_err_nxt;
  logic [2:0]       free_nxt;
  logic [1:0]       low_free;
  logic             serve_entry, serve_exit;

  // Lowest-index free slot; only consumed when the lot is not full.
  always_comb begin
    low_free = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!occupancy[i]) low_free = 2'(i);
    end
  end

  assign serve_entry = entry_req & (~exit_req | ~ptr_exit);
  assign serve_exit  = exit_req  & (~entry_req | ptr_exit);

  always_comb begin
    state_nxt      = state;
    timer_nxt      = timer;
    ptr_exit_nxt   = ptr_exit;
    occ_nxt        = occupancy;
    alloc_nxt      = alloc_slot;
    door_nxt       = door_open;
    entry_ack_nxt  = 1'b0;
    exit_ack_nxt   = 1'b0;
    entry_deny_nxt = 1'b0;
    exit_err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        // Any served request, accepted or refused, consumes the turn.
        if (serve_entry) begin
          ptr_exit_nxt = 1'b1;
          if (full) begin
            entry_deny_nxt = 1'b1;
          end else begin
            occ_nxt[low_free] = 1'b1;
            alloc_nxt         = low_free;
            entry_ack_nxt     = 1'b1;
            door_nxt          = 1'b1;
            timer_nxt         = TIMER_LOAD;
            state_nxt         = OPEN;
          end
        end else if (serve_exit) begin
          ptr_exit_nxt = 1'b0;
          if (occupancy[exit_slot]) begin
            occ_nxt[exit_slot] = 1'b0;
            exit_ack_nxt       = 1'b1;
            door_nxt           = 1'b1;
            timer_nxt          = TIMER_LOAD;
            state_nxt          = OPEN;
          end else begin
            exit_err_nxt = 1'b1;
          end
        end
      end
      OPEN: begin
        if (timer == '0) begin
          door_nxt  = 1'b0;
          state_nxt = HOLD;
        end else begin
          timer_nxt = timer - CNT_W'(1);
        end
      end
      HOLD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // free_count and full track the occupancy being written this edge.
  always_comb begin
    free_nxt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!occ_nxt[i]) free_nxt = free_nxt + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      ptr_exit   <= 1'b1;
      occupancy  <= 4'b0000;
      alloc_slot <= 2'd0;
      door_open  <= 1'b0;
      entry_ack  <= 1'b0;
      exit_ack   <= 1'b0;
      entry_deny <= 1'b0;
      exit_err   <= 1'b0;
      free_count <= 3'd4;
      full       <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      ptr_exit   <= ptr_exit_nxt;
      occupancy  <= occ_nxt;
      alloc_slot <= alloc_nxt;
      door_open  <= door_nxt;
      entry_ack  <= entry_ack_nxt;
      exit_ack   <= exit_ack_nxt;
      entry_deny <= entry_deny_nxt;
      exit_err   <= exit_err_nxt;
      free_count <= free_nxt;
      full       <= &occ_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Testbench for parking_gate_scheduler.  The reference model describes the gate
// as a timeline: a grant makes the gate busy for DOOR_CYCLES+1 further edges,
// the first DOOR_CYCLES of which have the door open; while not busy, requests
// are arbitrated with a "preferred lane" flag and the lot is a 4-entry array.
module tb_parking_gate_scheduler;

  localparam int DC = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_req, exit_req;
  logic [1:0] exit_slot;
  logic       entry_ack, exit_ack, entry_deny, exit_err;
  logic [1:0] alloc_slot;
  logic       door_open;
  logic [3:0] occupancy;
  logic [2:0] free_count;
  logic       full;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic [3:0] m_occ;
  bit         m_prefer_exit;
  int         m_busy, m_door_left;
  logic [1:0] m_alloc;
  bit         m_eack, m_xack, m_deny, m_err;

  logic [16:0] obs_vec;

  parking_gate_scheduler #(.DOOR_CYCLES(DC), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .entry_req(entry_req), .exit_req(exit_req), .exit_slot(exit_slot),
    .entry_ack(entry_ack), .exit_ack(exit_ack),
    .entry_deny(entry_deny), .exit_err(exit_err),
    .alloc_slot(alloc_slot), .door_open(door_open),
    .occupancy(occupancy), .free_count(free_count), .full(full),
    .state_dbg(state_dbg)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  assign obs_vec = {entry_ack, exit_ack, entry_deny, exit_err, door_open,
                    alloc_slot, occupancy, free_count, full, state_dbg};

  function automatic int popc(logic [3:0] v);
    int n = 0;
    for (int i = 0; i < 4; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [1:0] st;
    if (m_busy == 0)          st = 2'd0;
    else if (m_door_left > 0) st = 2'd1;
    else                      st = 2'd2;
    return {m_eack, m_xack, m_deny, m_err, (m_door_left > 0), m_alloc, m_occ,
            3'(4 - popc(m_occ)), (m_occ == 4'hF), st};
  endfunction

  task automatic model_edge();
    bit take_entry;
    bit found;
    m_eack = 0; m_xack = 0; m_deny = 0; m_err = 0;
    if (reset) begin
      m_occ = 4'b0000; m_prefer_exit = 1; m_busy = 0; m_door_left = 0; m_alloc = 2'd0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_door_left > 0) m_door_left--;
    end else if (entry_req || exit_req) begin
      take_entry    = entry_req && (!exit_req || !m_prefer_exit);
      m_prefer_exit = take_entry;
      if (take_entry) begin
        if (m_occ == 4'hF) m_deny = 1;
        else begin
          found = 0;
          for (int i = 0; i < 4; i++) begin
            if (!m_occ[i] && !found) begin
              found = 1; m_occ[i] = 1'b1; m_alloc = 2'(i);
            end
          end
          m_eack = 1; m_busy = DC + 1; m_door_left = DC;
        end
      end else begin
        if (m_occ[exit_slot]) begin
          m_occ[exit_slot] = 1'b0;
          m_xack = 1; m_busy = DC + 1; m_door_left = DC;
        end else m_err = 1;
      end
    end
  endtask

  // Driver: one clock edge; the requester drops a lane after its response.
  task automatic tick();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    if (m_eack || m_deny) entry_req = 1'b0;
    if (m_xack || m_err)  exit_req  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_state got=%h exp=%h", obs_vec, exp_vec());
    end
    checks++;
    if (occupancy !== 4'b0000 || free_count !== 3'd4 || full !== 1'b0 || door_open !== 1'b0) begin
      errors++; $display("FAIL reset_values got occ=%b free=%0d full=%b door=%b exp 0000/4/0/0",
                         occupancy, free_count, full, door_open);
    end
  endtask

  task automatic test_single_entry();
    int k;
    int door_cnt;
    entry_req = 1'b1;
    tick();
    checks++;
    if (obs_vec !== exp_vec()) begin
      errors++; $display("FAIL single_grant got=%h exp=%h", obs_vec, exp_vec());
    end
    checks++;
    if (entry_ack !== 1'b1 || alloc_slot !== 2'd0 || occupancy !== 4'b0001) begin
      errors++; $display("FAIL single_values got ack=%b slot=%0d occ=%b exp 1/0/0001",
                         entry_ack, alloc_slot, occupancy);
    end
    door_cnt = door_open ? 1 : 0;
    entry_req = 1'b1;
    k = 0;
    do begin
      tick();
      k++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL single_cycle k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
      end
      if (!entry_ack && door_open) door_cnt++;
    end while (!entry_ack && k < 20);
    checks++;
    if (k !== DC + 2 || entry_ack !== 1'b1) begin
      errors++; $display("FAIL single_next_grant got edges=%0d ack=%b exp edges=%0d", k, entry_ack, DC + 2);
    end
    checks++;
    if (door_cnt !== DC) begin
      errors++; $display("FAIL single_door_len got=%0d exp=%0d", door_cnt, DC);
    end
  endtask

  task automatic test_fill_and_deny();
    int k;
    do_reset();
    for (int e = 0; e < 5; e++) begin
      entry_req = 1'b1;
      k = 0;
      do begin
        tick();
        k++;
        checks++;
        if (obs_vec !== exp_vec()) begin
          errors++; $display("FAIL fill_cycle e=%0d got=%h exp=%h", e, obs_vec, exp_vec());
        end
      end while (!(entry_ack || entry_deny) && k < 14);
      checks++;
      if (e < 4) begin
        if (entry_ack !== 1'b1 || alloc_slot !== 2'(e)) begin
          errors++; $display("FAIL fill_alloc e=%0d got ack=%b slot=%0d exp 1/%0d", e, entry_ack, alloc_slot, e);
        end
      end else begin
        if (entry_deny !== 1'b1 || door_open !== 1'b0 || full !== 1'b1 || free_count !== 3'd0) begin
          errors++; $display("FAIL fill_deny got deny=%b door=%b full=%b free=%0d exp 1/0/1/0",
                             entry_deny, door_open, full, free_count);
        end
      end
    end
    tick();
    checks++;
    if (entry_deny !== 1'b0 || door_open !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL deny_after got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  // Runs right after test_fill_and_deny: lot full, exit lane preferred.
  task automatic test_exit_priority();
    int k;
    entry_req = 1'b1;
    exit_req  = 1'b1;
    exit_slot = 2'd2;
    tick();
    checks++;
    if (exit_ack !== 1'b1 || entry_ack !== 1'b0 || occupancy !== 4'b1011) begin
      errors++; $display("FAIL prio_exit_first got xack=%b eack=%b occ=%b exp 1/0/1011",
                         exit_ack, entry_ack, occupancy);
    end
    k = 0;
    do begin
      tick();
      k++;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL prio_cycle k=%0d got=%h exp=%h", k, obs_vec, exp_vec());
      end
    end while (!entry_ack && k < 14);
    checks++;
    if (k !== DC + 2 || alloc_slot !== 2'd2 || occupancy !== 4'b1111) begin
      errors++; $display("FAIL prio_entry_after got edges=%0d slot=%0d occ=%b exp %0d/2/1111",
                         k, alloc_slot, occupancy, DC + 2);
    end
  endtask

  task automatic test_alternate();
    int k;
    int last_cyc;
    bit last_was_exit, have_prev;
    do_reset();
    for (int e = 0; e < 2; e++) begin
      entry_req = 1'b1;
      k = 0;
      do begin tick(); k++; end while (!entry_ack && k < 14);
    end
    checks++;
    if (occupancy !== 4'b0011) begin
      errors++; $display("FAIL alt_setup got occ=%b exp 0011", occupancy);
    end
    have_prev = 0;
    last_cyc = 0;
    last_was_exit = 0;
    for (int c = 0; c < 6 * (DC + 2); c++) begin
      entry_req = 1'b1;
      exit_req  = 1'b1;
      exit_slot = 2'd0;
      for (int i = 3; i >= 0; i--) if (m_occ[i]) exit_slot = 2'(i);
      tick();
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL alt_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec());
      end
      if (entry_ack || exit_ack) begin
        if (have_prev) begin
          checks++;
          if (cyc - last_cyc !== DC + 2 || exit_ack === last_was_exit) begin
            errors++; $display("FAIL alt_pattern got gap=%0d exit=%b prev_exit=%b exp gap=%0d alternating",
                               cyc - last_cyc, exit_ack, last_was_exit, DC + 2);
          end
        end
        have_prev = 1;
        last_cyc = cyc;
        last_was_exit = exit_ack;
      end
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  task automatic test_exit_err();
    int k;
    do_reset();
    entry_req = 1'b1;
    tick();
    k = 0;
    do begin
      exit_req  = 1'b1;
      exit_slot = 2'd1;
      tick();
      k++;
    end while (!(exit_ack || exit_err) && k < 14);
    checks++;
    if (exit_err !== 1'b1 || occupancy !== 4'b0001 || door_open !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL exit_err got err=%b occ=%b door=%b vec=%h exp 1/0001/0 vec=%h",
                         exit_err, occupancy, door_open, obs_vec, exp_vec());
    end
    tick();
    checks++;
    if (exit_err !== 1'b0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL exit_err_pulse got=%h exp=%h", obs_vec, exp_vec());
    end
  endtask

  task automatic test_reset_mid_open();
    do_reset();
    entry_req = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (door_open !== 1'b1 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL mid_open_pre got=%h exp=%h", obs_vec, exp_vec());
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (door_open !== 1'b0 || occupancy !== 4'b0000 || state_dbg !== 2'd0 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL mid_open_reset got door=%b occ=%b state=%0d exp 0/0000/0",
                         door_open, occupancy, state_dbg);
    end
    entry_req = 1'b1;
    tick();
    checks++;
    if (entry_ack !== 1'b1 || alloc_slot !== 2'd0 || occupancy !== 4'b0001 || obs_vec !== exp_vec()) begin
      errors++; $display("FAIL mid_open_regrant got ack=%b slot=%0d occ=%b exp 1/0/0001",
                         entry_ack, alloc_slot, occupancy);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!entry_req && $urandom_range(0, 3) == 0) entry_req = 1'b1;
      if (!exit_req && $urandom_range(0, 3) == 0) begin
        exit_req  = 1'b1;
        exit_slot = 2'($urandom_range(0, 3));
      end
      reset = ($urandom_range(0, 199) == 0);
      tick();
      reset = 1'b0;
      checks++;
      if (obs_vec !== exp_vec()) begin
        errors++; $display("FAIL random_cycle c=%0d got=%h exp=%h", c, obs_vec, exp_vec());
      end
    end
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    entry_req = 1'b0;
    exit_req  = 1'b0;
    exit_slot = 2'd0;
    m_occ = 4'b0000; m_prefer_exit = 1; m_busy = 0; m_door_left = 0; m_alloc = 2'd0;
    m_eack = 0; m_xack = 0; m_deny = 0; m_err = 0;
    @(negedge clk);
    test_reset();
    test_single_entry();
    test_fill_and_deny();
    test_exit_priority();
    test_alternate();
    test_exit_err();
    test_reset_mid_open();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
